// File: rtl/dual_issue_scheduler.sv
// Issue-stage controller: dual-issues a decoded pair when legal, otherwise splits it
// (older slot first, younger slot held and issued alone next), with flush and split counting.
module dual_issue_scheduler #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              pair_valid_i,
  output logic              pair_ready_o,
  input  logic [31:0]       inst0_i,
  input  logic [31:0]       inst1_i,
  input  logic [CTRL_W-1:0] ctrl0_i,
  input  logic [CTRL_W-1:0] ctrl1_i,
  input  logic [4:0]        rd0_i,
  input  logic              rd_we0_i,
  input  logic [4:0]        rs1_1_i,
  input  logic [4:0]        rs2_1_i,
  input  logic [1:0]        rs_use1_i,
  input  logic              mem0_i,
  input  logic              mem1_i,
  input  logic              br0_i,
  input  logic              br1_i,
  input  logic              ex_ready_i,
  output logic              iss0_valid_o,
  output logic [31:0]       iss0_inst_o,
  output logic [CTRL_W-1:0] iss0_ctrl_o,
  output logic              iss1_valid_o,
  output logic [31:0]       iss1_inst_o,
  output logic [CTRL_W-1:0] iss1_ctrl_o,
  output logic [PERF_W-1:0] split_cnt_o
);

  typedef enum logic {StPair, StSplit} state_e;

  state_e              state_q, state_d;
  logic                iss0_valid_q, iss0_valid_d;
  logic [31:0]         iss0_inst_q, iss0_inst_d;
  logic [CTRL_W-1:0]   iss0_ctrl_q, iss0_ctrl_d;
  logic                iss1_valid_q, iss1_valid_d;
  logic [31:0]         iss1_inst_q, iss1_inst_d;
  logic [CTRL_W-1:0]   iss1_ctrl_q, iss1_ctrl_d;
  logic [31:0]         hold_inst_q, hold_inst_d;
  logic [CTRL_W-1:0]   hold_ctrl_q, hold_ctrl_d;
  logic [PERF_W-1:0]   split_cnt_q, split_cnt_d;

  logic raw, conflict, accept;

  // x0 as a destination never creates a dependency.
  assign raw = rd_we0_i && (rd0_i != 5'd0) &&
               ((rs_use1_i[0] && (rs1_1_i == rd0_i)) || (rs_use1_i[1] && (rs2_1_i == rd0_i)));
  assign conflict = raw || (mem0_i && mem1_i) || (br0_i && br1_i);

  assign pair_ready_o = (state_q == StPair) && ex_ready_i && !flush_i;
  assign accept       = pair_valid_i && pair_ready_o;

  always_comb begin
    state_d      = state_q;
    iss0_valid_d = iss0_valid_q;
    iss0_inst_d  = iss0_inst_q;
    iss0_ctrl_d  = iss0_ctrl_q;
    iss1_valid_d = iss1_valid_q;
    iss1_inst_d  = iss1_inst_q;
    iss1_ctrl_d  = iss1_ctrl_q;
    hold_inst_d  = hold_inst_q;
    hold_ctrl_d  = hold_ctrl_q;
    split_cnt_d  = split_cnt_q;

    if (flush_i) begin
      iss0_valid_d = 1'b0;
      iss1_valid_d = 1'b0;
      state_d      = StPair;
      hold_inst_d  = '0;
      hold_ctrl_d  = '0;
    end else if (ex_ready_i) begin
      unique case (state_q)
        StPair: begin
          if (accept) begin
            iss0_valid_d = 1'b1;
            iss0_inst_d  = inst0_i;
            iss0_ctrl_d  = ctrl0_i;
            if (conflict) begin
              iss1_valid_d = 1'b0;
              hold_inst_d  = inst1_i;
              hold_ctrl_d  = ctrl1_i;
              state_d      = StSplit;
              if (split_cnt_q != '1) split_cnt_d = split_cnt_q + PERF_W'(1);
            end else begin
              iss1_valid_d = 1'b1;
              iss1_inst_d  = inst1_i;
              iss1_ctrl_d  = ctrl1_i;
            end
          end else begin
            iss0_valid_d = 1'b0;
            iss1_valid_d = 1'b0;
          end
        end
        StSplit: begin
          // Held younger instruction always issues on the older lane.
          iss0_valid_d = 1'b1;
          iss0_inst_d  = hold_inst_q;
          iss0_ctrl_d  = hold_ctrl_q;
          iss1_valid_d = 1'b0;
          state_d      = StPair;
        end
        default: state_d = StPair;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StPair;
      iss0_valid_q <= 1'b0;
      iss0_inst_q  <= '0;
      iss0_ctrl_q  <= '0;
      iss1_valid_q <= 1'b0;
      iss1_inst_q  <= '0;
      iss1_ctrl_q  <= '0;
      hold_inst_q  <= '0;
      hold_ctrl_q  <= '0;
      split_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      iss0_valid_q <= iss0_valid_d;
      iss0_inst_q  <= iss0_inst_d;
      iss0_ctrl_q  <= iss0_ctrl_d;
      iss1_valid_q <= iss1_valid_d;
      iss1_inst_q  <= iss1_inst_d;
      iss1_ctrl_q  <= iss1_ctrl_d;
      hold_inst_q  <= hold_inst_d;
      hold_ctrl_q  <= hold_ctrl_d;
      split_cnt_q  <= split_cnt_d;
    end
  end

  assign iss0_valid_o = iss0_valid_q;
  assign iss0_inst_o  = iss0_inst_q;
  assign iss0_ctrl_o  = iss0_ctrl_q;
  assign iss1_valid_o = iss1_valid_q;
  assign iss1_inst_o  = iss1_inst_q;
  assign iss1_ctrl_o  = iss1_ctrl_q;
  assign split_cnt_o  = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler; a narrow split counter keeps saturation reachable.
module tb_dual_issue_scheduler;

  localparam int unsigned CTRL_W = 32;
  localparam int unsigned PERF_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              pair_valid_i;
  logic              pair_ready_o;
  logic [31:0]       inst0_i, inst1_i;
  logic [CTRL_W-1:0] ctrl0_i, ctrl1_i;
  logic [4:0]        rd0_i, rs1_1_i, rs2_1_i;
  logic              rd_we0_i;
  logic [1:0]        rs_use1_i;
  logic              mem0_i, mem1_i, br0_i, br1_i;
  logic              ex_ready_i;
  logic              iss0_valid_o, iss1_valid_o;
  logic [31:0]       iss0_inst_o, iss1_inst_o;
  logic [CTRL_W-1:0] iss0_ctrl_o, iss1_ctrl_o;
  logic [PERF_W-1:0] split_cnt_o;

  dual_issue_scheduler #(.CTRL_W(CTRL_W), .PERF_W(PERF_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .pair_valid_i(pair_valid_i), .pair_ready_o(pair_ready_o),
    .inst0_i(inst0_i), .inst1_i(inst1_i), .ctrl0_i(ctrl0_i), .ctrl1_i(ctrl1_i),
    .rd0_i(rd0_i), .rd_we0_i(rd_we0_i), .rs1_1_i(rs1_1_i), .rs2_1_i(rs2_1_i),
    .rs_use1_i(rs_use1_i), .mem0_i(mem0_i), .mem1_i(mem1_i), .br0_i(br0_i), .br1_i(br1_i),
    .ex_ready_i(ex_ready_i),
    .iss0_valid_o(iss0_valid_o), .iss0_inst_o(iss0_inst_o), .iss0_ctrl_o(iss0_ctrl_o),
    .iss1_valid_o(iss1_valid_o), .iss1_inst_o(iss1_inst_o), .iss1_ctrl_o(iss1_ctrl_o),
    .split_cnt_o(split_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        v1;
    logic [31:0] i0, c0, i1, c1;
  } grp_t;

  grp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] c0_of(input logic [31:0] i);
    return i ^ 32'hC0C0_0000;
  endfunction
  function automatic logic [31:0] c1_of(input logic [31:0] i);
    return i ^ 32'hC1C1_0000;
  endfunction

  task automatic push_grp(input logic v1, input logic [31:0] i0, c0, i1, c1);
    grp_t g;
    g.v1 = v1; g.i0 = i0; g.c0 = c0; g.i1 = i1; g.c1 = c1;
    exp_q.push_back(g);
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] i0, i1, input logic [4:0] rd0, input logic we0,
                            input logic [4:0] rs1, rs2, input logic [1:0] use1,
                            input logic m0, m1, b0, b1);
    inst0_i = i0; inst1_i = i1; ctrl0_i = c0_of(i0); ctrl1_i = c1_of(i1);
    rd0_i = rd0; rd_we0_i = we0; rs1_1_i = rs1; rs2_1_i = rs2; rs_use1_i = use1;
    mem0_i = m0; mem1_i = m1; br0_i = b0; br1_i = b1;
    pair_valid_i = 1'b1;
  endtask

  // Monitor: a fresh issue group appears after every edge that was allowed to load one.
  logic ld;
  always @(posedge clk_i) begin
    grp_t g;
    ld = ex_ready_i && !flush_i && !rst_i;
    #2;
    if (ld && (iss0_valid_o || iss1_valid_o)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got lane0 %0h v1=%0b expected no issue",
                 iss0_inst_o, iss1_valid_o);
      end else begin
        g = exp_q.pop_front();
        check("lane0_valid", 32'(iss0_valid_o), 32'd1);
        check("lane0_inst", iss0_inst_o, g.i0);
        check("lane0_ctrl", iss0_ctrl_o, g.c0);
        check("lane1_valid", 32'(iss1_valid_o), 32'(g.v1));
        if (g.v1) begin
          check("lane1_inst", iss1_inst_o, g.i1);
          check("lane1_ctrl", iss1_ctrl_o, g.c1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst_i = 1'b1; flush_i = 1'b0; pair_valid_i = 1'b0; ex_ready_i = 1'b1;
    drive_pair(32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    pair_valid_i = 1'b0;
    repeat (2) cycle();
    check("rst_v0", 32'(iss0_valid_o), 32'd0);
    check("rst_v1", 32'(iss1_valid_o), 32'd0);
    check("rst_inst0", iss0_inst_o, 32'd0);
    check("rst_cnt", 32'(split_cnt_o), 32'd0);
    rst_i = 1'b0;
    check("ready_idle", 32'(pair_ready_o), 32'd1);

    // Independent pair: x1<-x2+x3, x4<-x5+x6
    drive_pair(32'h003100B3, 32'h00628233, 5'd1, 1'b1, 5'd5, 5'd6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_grp(1'b1, 32'h003100B3, c0_of(32'h003100B3), 32'h00628233, c1_of(32'h00628233));
    cycle();
    check("cnt_indep", 32'(split_cnt_o), 32'd0);

    // RAW on x5 through rs1
    drive_pair(32'h00A00293, 32'h00528333, 5'd5, 1'b1, 5'd5, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    push_grp(1'b0, 32'h00A00293, c0_of(32'h00A00293), 32'h0, 32'h0);
    push_grp(1'b0, 32'h00528333, c1_of(32'h00528333), 32'h0, 32'h0);
    check("ready_pair", 32'(pair_ready_o), 32'd1);
    cycle();
    check("ready_split", 32'(pair_ready_o), 32'd0);
    check("raw_lane1_off", 32'(iss1_valid_o), 32'd0);
    pair_valid_i = 1'b0;
    cycle();
    check("cnt_raw", 32'(split_cnt_o), 32'd1);

    // x0 destination never conflicts
    drive_pair(32'h11111111, 32'h22222222, 5'd0, 1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_grp(1'b1, 32'h11111111, c0_of(32'h11111111), 32'h22222222, c1_of(32'h22222222));
    cycle();
    // Two loads
    drive_pair(32'h33333333, 32'h44444444, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    push_grp(1'b0, 32'h33333333, c0_of(32'h33333333), 32'h0, 32'h0);
    push_grp(1'b0, 32'h44444444, c1_of(32'h44444444), 32'h0, 32'h0);
    cycle();
    pair_valid_i = 1'b0;
    cycle();
    // Two branches
    drive_pair(32'h55555555, 32'h66666666, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    push_grp(1'b0, 32'h55555555, c0_of(32'h55555555), 32'h0, 32'h0);
    push_grp(1'b0, 32'h66666666, c1_of(32'h66666666), 32'h0, 32'h0);
    cycle();
    pair_valid_i = 1'b0;
    cycle();
    check("cnt_mem_br", 32'(split_cnt_o), 32'd3);

    // Split stalled by execute for three cycles (RAW on x9 via rs2)
    drive_pair(32'h77777777, 32'h88888888, 5'd9, 1'b1, 5'd1, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    push_grp(1'b0, 32'h77777777, c0_of(32'h77777777), 32'h0, 32'h0);
    push_grp(1'b0, 32'h88888888, c1_of(32'h88888888), 32'h0, 32'h0);
    cycle();
    pair_valid_i = 1'b0;
    ex_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("frz_v0", 32'(iss0_valid_o), 32'd1);
      check("frz_inst0", iss0_inst_o, 32'h77777777);
      check("frz_v1", 32'(iss1_valid_o), 32'd0);
      check("frz_ready", 32'(pair_ready_o), 32'd0);
    end
    ex_ready_i = 1'b1;
    cycle();
    check("ready_after_release", 32'(pair_ready_o), 32'd1);
    check("cnt_frz", 32'(split_cnt_o), 32'd4);

    // Flush while split: held instruction is dropped, a pair in the flush cycle is refused
    drive_pair(32'h99999999, 32'hAAAAAAAA, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    push_grp(1'b0, 32'h99999999, c0_of(32'h99999999), 32'h0, 32'h0);
    cycle();
    drive_pair(32'hBBBBBBBB, 32'hCCCCCCCC, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    check("ready_flush", 32'(pair_ready_o), 32'd0);
    cycle();
    flush_i = 1'b0;
    pair_valid_i = 1'b0;
    check("flush_v0", 32'(iss0_valid_o), 32'd0);
    check("flush_v1", 32'(iss1_valid_o), 32'd0);
    check("flush_cnt", 32'(split_cnt_o), 32'd5);
    cycle();
    check("post_flush_v0", 32'(iss0_valid_o), 32'd0);
    check("post_flush_ready", 32'(pair_ready_o), 32'd1);

    // 2^PERF_W+5 conflicting pairs: count must stop at all-ones
    for (int k = 0; k < (1 << PERF_W) + 5; k++) begin
      a = 32'h1000_0000 + 32'(k);
      drive_pair(a, ~a, 5'd7, 1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      push_grp(1'b0, a, c0_of(a), 32'h0, 32'h0);
      push_grp(1'b0, ~a, c1_of(~a), 32'h0, 32'h0);
      cycle();
      pair_valid_i = 1'b0;
      cycle();
    end
    check("cnt_sat", 32'(split_cnt_o), 32'hF);

    // Async reset mid-split
    drive_pair(32'hDDDDDDDD, 32'hEEEEEEEE, 5'd3, 1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    push_grp(1'b0, 32'hDDDDDDDD, c0_of(32'hDDDDDDDD), 32'h0, 32'h0);
    cycle();
    pair_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_v0", 32'(iss0_valid_o), 32'd0);
    check("arst_inst0", iss0_inst_o, 32'd0);
    check("arst_v1", 32'(iss1_valid_o), 32'd0);
    check("arst_cnt", 32'(split_cnt_o), 32'd0);
    cycle();
    rst_i = 1'b0;
    cycle();
    check("arst_no_held_issue", 32'(iss0_valid_o), 32'd0);
    check("arst_ready", 32'(pair_ready_o), 32'd1);
    repeat (2) cycle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
